// File: rtl/data_memory.sv
// Word-organised MIPS data memory: synchronous write, combinational read, synchronous clear on rst.
// Optional access checking (accessErr port) is enabled by defining DMEM_ERR_CHECK_EN.
module data_memory #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  input  logic        MemRead,
  input  logic        MemWrite,
`ifdef DMEM_ERR_CHECK_EN
  output logic        accessErr,
`endif
  output logic [31:0] readData
);

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] word_idx;
  logic          in_range;
  logic          wr_en;
  logic          rd_en;

  assign word_idx = address[AW+1:2];

  // Upper address bits beyond the word index must be zero; at the largest depth none remain.
  generate
    if (AW + 2 < 32) begin : g_range
      assign in_range = (address[31:AW+2] == '0);
    end else begin : g_full
      assign in_range = 1'b1;
    end
  endgenerate

  assign wr_en = MemWrite && in_range;
  assign rd_en = MemRead && !rst && in_range;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[word_idx] <= writeData;
    end
  end

  assign readData = rd_en ? mem_q[word_idx] : 32'h0;

`ifdef DMEM_ERR_CHECK_EN
  // Misaligned accesses are flagged but still complete using the truncated index.
  assign accessErr = (MemRead || MemWrite) && !rst && ((address[1:0] != 2'b00) || !in_range);

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst && MemWrite && accessErr) begin
      $display("data_memory: warning, erroneous write to address 0x%08h", address);
    end
  end
`endif
`else
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^address[1:0];
`endif

endmodule

// File: tb/tb_data_memory.sv
// Randomised scoreboard bench for data_memory against an array-based reference model.
module tb_data_memory;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] address;
  logic [31:0] writeData;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] readData;
`ifdef DMEM_ERR_CHECK_EN
  logic        accessErr;
`endif

  always #5 clk = ~clk;

  data_memory #(.DEPTH(256), .AW(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .address   (address),
    .writeData (writeData),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
`ifdef DMEM_ERR_CHECK_EN
    .accessErr (accessErr),
`endif
    .readData  (readData)
  );

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          id;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] model [256];
  int          vectors   = 0;
  int          miscompares = 0;
  int          issued    = 0;

  // Model: 1 KiB byte space of 256 words; anything at or above 0x400 is out of range.
  task automatic step(input logic r, input logic mr, input logic mw,
                      input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    bit   ok;
    @(posedge clk);
    #1;
    rst = r; MemRead = mr; MemWrite = mw; address = a; writeData = d;
    ok    = (a < 32'h400);
    e.rd  = (!r && mr && ok) ? model[a / 4] : 32'h0;
    e.err = !r && (mr || mw) && ((a % 4 != 0) || !ok);
    e.id  = issued;
    issued++;
    sb_q.push_back(e);
    if (r) begin
      for (int i = 0; i < 256; i++) model[i] = 32'h0;
    end else if (mw && ok) begin
      model[a / 4] = d;
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        vectors++;
        if (readData !== e.rd) begin
          miscompares++;
          $display("FAIL readData vec %0d: got %08h expected %08h", e.id, readData, e.rd);
        end
`ifdef DMEM_ERR_CHECK_EN
        if (accessErr !== e.err) begin
          miscompares++;
          $display("FAIL accessErr vec %0d: got %0b expected %0b", e.id, accessErr, e.err);
        end
`endif
      end
    end
  end

  initial begin : stimulus
    logic [31:0] a;
    logic [31:0] hot [4];
    int          kind;
    rst = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; address = '0; writeData = '0;
    for (int i = 0; i < 256; i++) model[i] = 32'h0;

    step(1, 0, 0, 32'h0, 32'h0);
    step(1, 0, 0, 32'h0, 32'h0);
    step(0, 1, 0, 32'h0, 32'h0);

    for (int i = 0; i < 4; i++) step(0, 0, 1, 32'h0, 32'h5);
    step(0, 1, 0, 32'h0, 32'h0);
    step(0, 0, 0, 32'h0, 32'h0);

    step(0, 0, 1, 32'h4,   32'hDEADBEEF);
    step(0, 0, 1, 32'h3FC, 32'h12345678);
    step(0, 1, 0, 32'h4,   32'h0);
    step(0, 1, 0, 32'h3FC, 32'h0);
    step(1, 0, 0, 32'h0,   32'h0);
    step(0, 1, 0, 32'h0,   32'h0);
    step(0, 1, 0, 32'h4,   32'h0);

    step(0, 0, 1, 32'h0,   32'h77);
    step(0, 0, 1, 32'h400, 32'hFFFFFFFF);
    step(0, 1, 0, 32'h400, 32'h0);
    step(0, 1, 0, 32'h0,   32'h0);

    step(0, 0, 1, 32'h8, 32'h11);
    step(0, 1, 1, 32'h8, 32'h22);
    step(0, 1, 0, 32'h8, 32'h0);

    step(0, 0, 1, 32'h14, 32'h33);
    step(1, 0, 1, 32'h10, 32'hAA);
    step(0, 1, 0, 32'h10, 32'h0);
    step(0, 1, 0, 32'h14, 32'h0);
    step(0, 1, 0, 32'h8,  32'h0);
    step(0, 1, 0, 32'h0,  32'h0);

    // A few hot addresses make read-after-write collisions frequent in the random phase.
    hot[0] = 32'h0; hot[1] = 32'h20; hot[2] = 32'h3FC; hot[3] = 32'h401;
    for (int n = 0; n < 600; n++) begin
      kind = $urandom_range(0, 9);
      if (kind < 4)      a = hot[$urandom_range(0, 3)];
      else if (kind < 8) a = $urandom_range(0, 32'h3FF);
      else if (kind < 9) a = 32'h400 + $urandom_range(0, 32'hFFF);
      else               a = $urandom;
      step(($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom);
    end
    step(0, 0, 0, 32'h0, 32'h0);

    @(posedge clk);
    @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
